// File: rtl/wavepool_rf8_ctrl.sv
// wavepool_rf8_ctrl: 8x64 RF controller with round-robin write arbitration, post-reset clear and registered reads.
// Define WAVEPOOL_RF8_WR_BYPASS_EN to forward same-cycle write data to a colliding read.
module wavepool_rf8_ctrl #(
  parameter int DW = 64,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  input  logic          wa_req,
  input  logic [AW-1:0] wa_addr,
  input  logic [DW-1:0] wa_data,
  output logic          wa_ack,
  input  logic          wb_req,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ack,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic [AW-1:0] rf_rd_addr,
  input  logic [DW-1:0] rf_rd_data
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d, wr_addr_q;
  logic [DW-1:0] wr_data_q, rd_data_q, rd_fwd;
  logic          rr_ptr_q, rr_ptr_d, rd_valid_q;
  logic          clearing, run, gnt_a, gnt_b, rd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rr_ptr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clr_req) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
    end else if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      state_d   = &clr_cnt_q ? RUN : CLEAR;
    end
  end

  // rr_ptr: 0 favours A, 1 favours B; it only flips when both contend.
  assign clearing = !rst && state_q == CLEAR;
  assign run      = !rst && state_q == RUN;
  assign gnt_a    = run && wa_req && (!wb_req || !rr_ptr_q);
  assign gnt_b    = run && wb_req && (!wa_req || rr_ptr_q);
  assign rr_ptr_d = (run && wa_req && wb_req) ? ~rr_ptr_q : rr_ptr_q;

  always_comb begin
    busy       = rst || state_q == CLEAR;
    wa_ack     = gnt_a;
    wb_ack     = gnt_b;
    rf_wr_en   = clearing || gnt_a || gnt_b;
    rf_wr_addr = clearing ? clr_cnt_q : gnt_a ? wa_addr : gnt_b ? wb_addr : wr_addr_q;
    rf_wr_data = clearing ? '0 : gnt_a ? wa_data : gnt_b ? wb_data : wr_data_q;
    rf_rd_addr = rd_addr;
    rd_valid   = !rst && rd_valid_q;
    rd_data    = rst ? '0 : rd_data_q;
  end

  assign rd_fire = rd_req && !busy;
`ifdef WAVEPOOL_RF8_WR_BYPASS_EN
  assign rd_fwd = (rf_wr_en && rf_wr_addr == rd_addr) ? rf_wr_data : rf_rd_data;
`else
  assign rd_fwd = rf_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_data_q <= rd_fwd;
      if (rf_wr_en) begin
        wr_addr_q <= rf_wr_addr;
        wr_data_q <= rf_wr_data;
      end
    end
  end
endmodule

// File: tb/tb_wavepool_rf8_ctrl.sv
// tb_wavepool_rf8_ctrl: table-driven bench for wavepool_rf8_ctrl with a behavioural 8x64 register file.
module tb_wavepool_rf8_ctrl;
  typedef struct {
    logic clr, ar; logic [2:0] aa; logic [63:0] ad;
    logic br; logic [2:0] ba; logic [63:0] bd;
    logic rr; logic [2:0] ra;
    logic e_busy, e_aack, e_back, e_wen; logic [2:0] e_waddr; logic [63:0] e_wdata;
    logic e_rv; logic [63:0] e_rd;
  } vec_t;

  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0001;
`ifdef WAVEPOOL_RF8_WR_BYPASS_EN
  localparam logic [63:0] SAME = 64'h2;
`else
  localparam logic [63:0] SAME = 64'h1;
`endif

  logic clk = 0, rst = 1, clr_req = 0, busy;
  logic wa_req = 0, wa_ack, wb_req = 0, wb_ack, rd_req = 0, rd_valid, rf_wr_en;
  logic [2:0] wa_addr = 0, wb_addr = 0, rd_addr = 0, rf_wr_addr, rf_rd_addr;
  logic [63:0] wa_data = 0, wb_data = 0, rd_data, rf_wr_data, rf_rd_data;
  logic [63:0] mem [8];
  int total = 0, bad = 0;
  vec_t tbl [20];

  always #5 clk = ~clk;

  wavepool_rf8_ctrl dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .wa_req(wa_req), .wa_addr(wa_addr), .wa_data(wa_data), .wa_ack(wa_ack),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  always @(posedge clk) if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data = mem[rf_rd_addr];

  function automatic vec_t mk(
    input logic clr, ar, input logic [2:0] aa, input logic [63:0] ad,
    input logic br, input logic [2:0] ba, input logic [63:0] bd,
    input logic rr, input logic [2:0] ra,
    input logic busy_e, aack, back, wen, input logic [2:0] waddr, input logic [63:0] wdata,
    input logic rv, input logic [63:0] rd);
    vec_t v;
    v.clr = clr; v.ar = ar; v.aa = aa; v.ad = ad; v.br = br; v.ba = ba; v.bd = bd;
    v.rr = rr; v.ra = ra; v.e_busy = busy_e; v.e_aack = aack; v.e_back = back;
    v.e_wen = wen; v.e_waddr = waddr; v.e_wdata = wdata; v.e_rv = rv; v.e_rd = rd;
    return v;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    clr_req = v.clr; wa_req = v.ar; wa_addr = v.aa; wa_data = v.ad;
    wb_req = v.br; wb_addr = v.ba; wb_data = v.bd; rd_req = v.rr; rd_addr = v.ra;
    @(negedge clk);
    chk({tag, ".busy"}, 64'(busy), 64'(v.e_busy));
    chk({tag, ".wa_ack"}, 64'(wa_ack), 64'(v.e_aack));
    chk({tag, ".wb_ack"}, 64'(wb_ack), 64'(v.e_back));
    chk({tag, ".rf_wr_en"}, 64'(rf_wr_en), 64'(v.e_wen));
    if (v.e_wen) begin
      chk({tag, ".rf_wr_addr"}, 64'(rf_wr_addr), 64'(v.e_waddr));
      chk({tag, ".rf_wr_data"}, rf_wr_data, v.e_wdata);
    end
    chk({tag, ".rf_rd_addr"}, 64'(rf_rd_addr), 64'(v.ra));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(v.e_rv));
    chk({tag, ".rd_data"}, rd_data, v.e_rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 64'hBAD0_0000_0000_0000 | 64'(i);
    tbl[0]  = mk(0,1,3,D1,0,0,0,0,0,          0,1,0,1,3,D1,0,0);
    tbl[1]  = mk(0,0,0,0,0,0,0,1,3,           0,0,0,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,1,D1);
    tbl[3]  = mk(0,1,1,'hA0,1,2,'hB0,0,0,     0,1,0,1,1,'hA0,0,D1);
    tbl[4]  = mk(0,1,1,'hA1,1,2,'hB0,0,0,     0,0,1,1,2,'hB0,0,D1);
    tbl[5]  = mk(0,1,1,'hA1,1,2,'hB1,0,0,     0,1,0,1,1,'hA1,0,D1);
    tbl[6]  = mk(0,1,1,'hA2,1,2,'hB1,0,0,     0,0,1,1,2,'hB1,0,D1);
    tbl[7]  = mk(0,1,1,'hA2,1,2,'hB2,0,0,     0,1,0,1,1,'hA2,0,D1);
    tbl[8]  = mk(0,1,1,'hA3,1,2,'hB2,0,0,     0,0,1,1,2,'hB2,0,D1);
    tbl[9]  = mk(0,1,1,'hA3,1,2,'hB3,0,0,     0,1,0,1,1,'hA3,0,D1);
    tbl[10] = mk(0,0,0,0,1,2,'hB3,0,0,        0,0,1,1,2,'hB3,0,D1);
    tbl[11] = mk(0,1,6,'h61,1,7,'h71,0,0,     0,0,1,1,7,'h71,0,D1);
    tbl[12] = mk(0,1,6,'h61,0,0,0,0,0,        0,1,0,1,6,'h61,0,D1);
    tbl[13] = mk(0,0,0,0,0,0,0,1,1,           0,0,0,0,0,0,0,D1);
    tbl[14] = mk(0,0,0,0,0,0,0,1,2,           0,0,0,0,0,0,1,'hA3);
    tbl[15] = mk(0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,1,'hB3);
    tbl[16] = mk(0,1,5,1,0,0,0,0,0,           0,1,0,1,5,1,0,'hB3);
    tbl[17] = mk(0,1,5,2,0,0,0,1,5,           0,1,0,1,5,2,0,'hB3);
    tbl[18] = mk(0,0,0,0,0,0,0,1,5,           0,0,0,0,0,0,1,SAME);
    tbl[19] = mk(0,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,1,2);
    rst = 1;
    for (int i = 0; i < 2; i++) step("reset", mk(0,1,2,'h55,1,3,'h66,1,0, 1,0,0,0,0,0,0,0));
    rst = 0;
    for (int i = 0; i < 8; i++) step("init_clear", mk(0,0,0,0,0,0,0,1,0, 1,0,0,1,3'(i),0,0,0));
    for (int i = 0; i < 20; i++) step($sformatf("row%0d", i), tbl[i]);
    step("clr_mid_write", mk(1,1,4,'h44,0,0,0,0,0, 0,1,0,1,4,'h44,0,2));
    for (int i = 0; i < 8; i++) step("clr_mid_busy", mk(0,0,0,0,1,1,'hFF,1,4, 1,0,0,1,3'(i),0,0,2));
    step("clr_mid_rd", mk(0,0,0,0,0,0,0,1,4, 0,0,0,0,0,0,0,2));
    step("clr_mid_rd4", mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0));
    step("rmc_wr3", mk(0,1,3,'h33,0,0,0,0,0, 0,1,0,1,3,'h33,0,0));
    step("rmc_rd3", mk(0,0,0,0,0,0,0,1,3, 0,0,0,0,0,0,0,0));
    step("rmc_clr", mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,'h33));
    for (int i = 0; i < 4; i++) step("rmc_clear", mk(0,0,0,0,0,0,0,0,0, 1,0,0,1,3'(i),0,0,'h33));
    rst = 1;
    for (int i = 0; i < 2; i++) step("rmc_reset", mk(0,1,2,'h55,1,3,'h66,1,0, 1,0,0,0,0,0,0,0));
    rst = 0;
    for (int k = 0; k < 11; k++)
      step("rmc_restart", mk(k == 2,0,0,0,0,0,0,0,0, 1,0,0,1,3'(k < 3 ? k : k - 3),0,0,0));
    step("rmc_idle", mk(0,0,0,0,0,0,0,1,4, 0,0,0,0,0,0,0,0));
    step("rmc_rd4", mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wavepool_rf8_ctrl.md
Name: wavepool_rf8_ctrl

Overview:
- Controller for an 8-entry x 64-bit, single-read/single-write register file in the wavepool.
- Shares the one write port between two requesters (A, B) using round-robin arbitration.
- Sequences a reads-disabled clear of all 8 entries after reset, and again on a clear request.
- Returns read data registered, one cycle after the request.

Parameters:
- DW, 64, entry data width.
- AW, 3, entry address width (8 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  pulse; re-runs the clear sequence.
- busy  out  1  high while in reset or clear.
- wa_req  in  1  requester A write request; held until acked.
- wa_addr  in  AW  requester A write address.
- wa_data  in  DW  requester A write data.
- wa_ack  out  1  requester A write accepted this cycle.
- wb_req  in  1  requester B write request; held until acked.
- wb_addr  in  AW  requester B write address.
- wb_data  in  DW  requester B write data.
- wb_ack  out  1  requester B write accepted this cycle.
- rd_req  in  1  read request.
- rd_addr  in  AW  read address.
- rd_valid  out  1  rd_data valid.
- rd_data  out  DW  registered read data.
- rf_wr_en  out  1  register file write enable.
- rf_wr_addr  out  AW  register file write address.
- rf_wr_data  out  DW  register file write data.
- rf_rd_addr  out  AW  register file read address.
- rf_rd_data  in  DW  register file combinational read data.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high, and has priority over everything.
- While rst=1:
  - State forced to CLEAR with clr_cnt=0 and rr_ptr=A.
  - busy=1; rf_wr_en=0, wa_ack=0, wb_ack=0, rd_valid=0, rd_data=0.
- State CLEAR:
  - Each cycle: rf_wr_en=1, rf_wr_addr=clr_cnt, rf_wr_data=0; clr_cnt increments.
  - After the cycle with clr_cnt=7, go to RUN. The sequence is exactly 8 cycles after rst falls.
  - busy=1 throughout; no acks are issued.
  - rd_req is ignored: rd_valid=0 next cycle. Requesters retry when busy=0.
  - clr_req during CLEAR restarts clr_cnt at 0.
- State RUN:
  - busy=0.
  - clr_req=1 moves to CLEAR next cycle with clr_cnt=0. A write granted in that same cycle still completes.
- Write arbitration (RUN only, combinational, same-cycle ack):
  - Only one requesting: that requester is granted.
  - Both requesting: the requester indicated by rr_ptr is granted; rr_ptr then points to the other requester.
  - rr_ptr updates only on a contested grant.
  - Grant cycle: rf_wr_en=1; rf_wr_addr/rf_wr_data come from the winner; the winner's ack=1.
  - The ack is a 1-cycle pulse. Each req/addr/data triple is written exactly once.
  - The loser keeps req asserted, so back-to-back contention alternates A, B, A, B...
  - No request: rf_wr_en=0. rf_wr_addr and rf_wr_data hold their last value (don't-care).
- Read:
  - rf_rd_addr = rd_addr (combinational) at all times.
  - rd_req=1 and busy=0 in cycle N: in cycle N+1, rd_valid=1 and rd_data = rf_rd_data sampled at end of cycle N.
  - Otherwise rd_valid=0 and rd_data holds its value.
  - Back-to-back reads give one result per cycle.
- Same-cycle read and write to the same address (default): the read returns the OLD contents.
- No requester is starved: under continuous contention, each waits at most 1 cycle.

Optional Feature:
- Macro: WAVEPOOL_RF8_WR_BYPASS_EN.
- Defined: if a read is accepted in cycle N while rf_wr_en=1 and rf_wr_addr==rd_addr in cycle N, then rd_data in N+1 equals the write data (read-after-write forwarding). This includes CLEAR writes, but CLEAR reads are ignored anyway.
- Undefined: no forwarding; the old contents are returned.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, then low.
  - Response: busy=1 for 8 cycles with rf_wr_addr 0..7 and data 0; busy=0 on cycle 9; no acks throughout.
- Single requester:
  - Stimulus: wa_req, addr 3, data 64'hDEAD_BEEF_0000_0001.
  - Response: wa_ack and rf_wr_en in the same cycle; then rd_req addr 3 gives rd_valid with that value one cycle later.
- Contention:
  - Stimulus: A and B both hold req for 4 writes each (A addr 1, B addr 2).
  - Response: grant order A, B, A, B... from the reset rr_ptr; 8 grants in 8 cycles; each ack is a 1-cycle pulse.
- Same-address read and write:
  - Stimulus: addr 5 holds 64'h1; write 64'h2 to addr 5 and read addr 5 in the same cycle.
  - Response: rd_data=64'h1 without the macro, 64'h2 with it.
- Clear mid-operation:
  - Stimulus: clr_req while A writes addr 4.
  - Response: the A write is acked; then busy=1 for 8 cycles; reads during busy give no rd_valid; a later read of addr 4 returns 0.
- Reset mid-clear:
  - Stimulus: rst at clr_cnt=4.
  - Response: the clear restarts at addr 0 after rst falls; all outputs hold their reset values while rst=1.
